// File: rtl/register_file_bypass.sv
// 16x16 architectural register file: two combinational read ports, one write port,
// same-cycle write-to-read bypass, optional hardwired-zero R0.
module register_file_bypass #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter bit HARDWIRE_R0 = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] SrcReg1,
  input  logic [ADDR_WIDTH-1:0] SrcReg2,
  input  logic [ADDR_WIDTH-1:0] DstReg,
  input  logic                  WriteReg,
  input  logic [DATA_WIDTH-1:0] DstData,
  output logic [DATA_WIDTH-1:0] SrcData1,
  output logic [DATA_WIDTH-1:0] SrcData2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_line;
  logic [NUM_REGS-1:0]   rd_line1;
  logic [NUM_REGS-1:0]   rd_line2;
  logic [DATA_WIDTH-1:0] stored1;
  logic [DATA_WIDTH-1:0] stored2;
  logic                  bypass1;
  logic                  bypass2;

  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] idx);
    logic [NUM_REGS-1:0] line;
    line      = '0;
    line[idx] = 1'b1;
    return line;
  endfunction

  // Masking wordline 0 when R0 is hardwired kills both its write and its bypass.
  always_comb begin
    wr_line  = WriteReg ? decode(DstReg) : '0;
    rd_line1 = decode(SrcReg1);
    rd_line2 = decode(SrcReg2);
    if (HARDWIRE_R0) begin
      wr_line[0]  = 1'b0;
      rd_line1[0] = 1'b0;
      rd_line2[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_line[i]) regs[i] <= DstData;
      end
    end
  end

  // AND-OR read mux: each wordline gates its register, results ORed per bit.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      stored1 = stored1 | (regs[i] & {DATA_WIDTH{rd_line1[i]}});
      stored2 = stored2 | (regs[i] & {DATA_WIDTH{rd_line2[i]}});
    end
  end

  assign bypass1 = !rst && |(wr_line & rd_line1);
  assign bypass2 = !rst && |(wr_line & rd_line2);

  always_comb begin
    SrcData1 = '0;
    SrcData2 = '0;
    if (!rst) begin
      SrcData1 = bypass1 ? DstData : stored1;
      SrcData2 = bypass2 ? DstData : stored2;
    end
  end

endmodule

// File: tb/tb_register_file_bypass.sv
// Directed bench for register_file_bypass: vector table plus reset, write-during-reset
// and hardwired-R0 sequences on a second instance.
module tb_register_file_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  SrcReg1, SrcReg2, DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1, SrcData2;
  logic [15:0] hw_SrcData1, hw_SrcData2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file_bypass #(.HARDWIRE_R0(1'b0)) dut (
    .clk(clk), .rst(rst), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .DstReg(DstReg),
    .WriteReg(WriteReg), .DstData(DstData), .SrcData1(SrcData1), .SrcData2(SrcData2)
  );

  register_file_bypass #(.HARDWIRE_R0(1'b1)) dut_hw (
    .clk(clk), .rst(rst), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .DstReg(DstReg),
    .WriteReg(WriteReg), .DstData(DstData), .SrcData1(hw_SrcData1), .SrcData2(hw_SrcData2)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  dst;
    logic [15:0] data;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        step;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [3:0] dst, input logic [15:0] data,
                       input logic [3:0] s1, input logic [3:0] s2);
    WriteReg = wr;
    DstReg   = dst;
    DstData  = data;
    SrcReg1  = s1;
    SrcReg2  = s2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input logic [3:0] dst, input logic [15:0] data,
                              input logic [3:0] s1, input logic [3:0] s2, input logic step,
                              input logic [15:0] e1, input logic [15:0] e2);
    vec_t v;
    v.wr = wr; v.dst = dst; v.data = data; v.s1 = s1; v.s2 = s2;
    v.step = step; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(1'b1, 4'd3,  16'h1234, 4'd3,  4'd0,  1'b1, 16'h1234, 16'h0000);
    vecs[1]  = mk(1'b1, 4'd12, 16'hBEEF, 4'd3,  4'd12, 1'b1, 16'h1234, 16'hBEEF);
    vecs[2]  = mk(1'b0, 4'd0,  16'h0000, 4'd3,  4'd12, 1'b0, 16'h1234, 16'hBEEF);
    vecs[3]  = mk(1'b1, 4'd5,  16'h00AA, 4'd5,  4'd3,  1'b1, 16'h00AA, 16'h1234);
    vecs[4]  = mk(1'b1, 4'd5,  16'h5555, 4'd5,  4'd5,  1'b1, 16'h5555, 16'h5555);
    vecs[5]  = mk(1'b0, 4'd5,  16'h0000, 4'd5,  4'd5,  1'b0, 16'h5555, 16'h5555);
    vecs[6]  = mk(1'b1, 4'd6,  16'h0006, 4'd0,  4'd6,  1'b1, 16'h0000, 16'h0006);
    vecs[7]  = mk(1'b1, 4'd7,  16'h7777, 4'd6,  4'd7,  1'b1, 16'h0006, 16'h7777);
    vecs[8]  = mk(1'b0, 4'd7,  16'h0000, 4'd7,  4'd6,  1'b1, 16'h7777, 16'h0006);
    vecs[9]  = mk(1'b0, 4'd0,  16'h0000, 4'd7,  4'd12, 1'b0, 16'h7777, 16'hBEEF);
    vecs[10] = mk(1'b1, 4'd15, 16'hA5A5, 4'd15, 4'd14, 1'b1, 16'hA5A5, 16'h0000);
    vecs[11] = mk(1'b0, 4'd0,  16'h0000, 4'd15, 4'd14, 1'b0, 16'hA5A5, 16'h0000);

    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
    #2;
    check("reset_init_p1", SrcData1, 16'h0000);
    check("reset_init_p2", SrcData2, 16'h0000);
    tick();
    rst = 1'b0;

    // Fill R1..R15 with all-ones, then pulse reset between edges.
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, 4'(i), 16'hFFFF, 4'd0, 4'd0);
      tick();
    end
    drive(1'b0, 4'd0, 16'h0000, 4'd1, 4'd15);
    #1;
    check("fill_r1", SrcData1, 16'hFFFF);
    check("fill_r15", SrcData2, 16'hFFFF);
    #1;
    rst = 1'b1;
    #1;
    check("reset_async_p1", SrcData1, 16'h0000);
    check("reset_async_p2", SrcData2, 16'h0000);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 16'h0000, 4'(i), 4'(15 - i));
      #1;
      check($sformatf("reset_cleared_p1_r%0d", i), SrcData1, 16'h0000);
      check($sformatf("reset_cleared_p2_r%0d", 15 - i), SrcData2, 16'h0000);
    end
    tick();

    foreach (vecs[k]) begin
      drive(vecs[k].wr, vecs[k].dst, vecs[k].data, vecs[k].s1, vecs[k].s2);
      #2;
      check($sformatf("vec%0d_p1", k), SrcData1, vecs[k].e1);
      check($sformatf("vec%0d_p2", k), SrcData2, vecs[k].e2);
      if (vecs[k].step) tick();
    end

    // Write coinciding with reset must be dropped and bypass suppressed.
    rst = 1'b1;
    drive(1'b1, 4'd9, 16'hCAFE, 4'd9, 4'd9);
    #1;
    check("wr_in_rst_bypass_p1", SrcData1, 16'h0000);
    check("wr_in_rst_bypass_p2", SrcData2, 16'h0000);
    tick();
    check("wr_in_rst_after_edge", SrcData1, 16'h0000);
    drive(1'b0, 4'd9, 16'hCAFE, 4'd9, 4'd5);
    rst = 1'b0;
    #1;
    check("wr_in_rst_r9", SrcData1, 16'h0000);
    check("wr_in_rst_r5_cleared", SrcData2, 16'h0000);
    drive(1'b1, 4'd9, 16'hCAFE, 4'd9, 4'd9);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 4'd9, 4'd9);
    #1;
    check("post_rst_write_r9", SrcData1, 16'hCAFE);

    // R0 behaviour: ordinary on dut, hardwired zero on dut_hw.
    drive(1'b1, 4'd0, 16'h1111, 4'd0, 4'd9);
    #1;
    check("r0_plain_bypass", SrcData1, 16'h1111);
    check("r0_hw_bypass", hw_SrcData1, 16'h0000);
    check("r0_hw_other_reg", hw_SrcData2, 16'hCAFE);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
    #1;
    check("r0_plain_stored_p1", SrcData1, 16'h1111);
    check("r0_plain_stored_p2", SrcData2, 16'h1111);
    check("r0_hw_stored_p1", hw_SrcData1, 16'h0000);
    check("r0_hw_stored_p2", hw_SrcData2, 16'h0000);
    drive(1'b1, 4'd4, 16'h4444, 4'd4, 4'd0);
    #1;
    check("hw_bypass_r4", hw_SrcData1, 16'h4444);
    check("hw_r0_during_wr", hw_SrcData2, 16'h0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
